instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/kgp_risc_pkg.sv | 25 ++
 rtl/instr_loader_timer.sv | 42 ++++
 rtl/instr_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: instruction-loader state encoding and the
// loader's default sizing constants.
package kgp_risc_pkg;

    // Default instruction-memory word-address width (1024 words)
    localparam int LOADER_ADDR_W  = 10;
    // Default idle-cycle budget between accepted bytes during a load
    localparam int LOADER_TIMEOUT = 1000000;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_BYTE   = 3'd3,
        LD_WRITE  = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERROR  = 3'd6
    } loader_state_e;

    // States in which the loader is waiting on the byte stream
    function automatic logic is_stream_state(loader_state_e s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_BYTE);
    endfunction

endpackage

// File: rtl/instr_loader_timer.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last
// clear and flags the cycle on which the count would reach TIMEOUT.
module loader_timer
    import kgp_risc_pkg::*;
#(
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // expired does not depend on enable, so the FSM can gate it without
    // creating a combinational loop through its own enable output.
    assign expired = (count_q == CW'(TIMEOUT - 1));

    // Next count: clear wins, otherwise step while enabled (saturating)
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Serial program loader: receives a 2-byte word count followed by that many
// big-endian 32-bit words, writes them to instruction memory from address 0,
// and holds the processor in reset until a load completes successfully.
module instr_loader
    import kgp_risc_pkg::*;
#(
    parameter int ADDR_W  = LOADER_ADDR_W,
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byteIn,
    input  logic              byteValid,
    output logic              byteReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [31:0]       wrData,
    output logic              cpuRst,
    output logic              done,
    output logic              error
);

    // Largest legal word count is the full memory, 2^ADDR_W words
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              byteReady_q, byteReady_d;
    logic              wrEn_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [31:0]       wrData_q;
    logic              cpuRst_q;
    logic              done_q;
    logic              error_q;

    logic              accept;
    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_expired;
    logic              len_ok_d;
    logic              enter_write;

    assign accept = byteValid && byteReady_q;

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state logic and datapath updates for the load sequence
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_d   = LD_LEN_HI;
                    idx_d     = '0;
                    cnt_d     = '0;
                    tmr_clear = 1'b1;
                end
            end
            LD_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byteIn;
                    state_d     = LD_LEN_LO;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) state_d = LD_ERROR;
                end
            end
            LD_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byteIn;
                    state_d    = LD_BYTE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) state_d = LD_ERROR;
                end
            end
            LD_BYTE: begin
                // The length is vetted on the first BYTE cycle; byteReady was
                // already held low for an unusable length so nothing is taken.
                if (len_q == 16'd0) begin
                    state_d = LD_DONE;
                end else if ({1'b0, len_q} > CAPACITY) begin
                    state_d = LD_ERROR;
                end else if (accept) begin
                    asm_d = {asm_q[23:0], byteIn};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = LD_WRITE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) state_d = LD_ERROR;
                end
            end
            LD_WRITE: begin
                idx_d = idx_q + 1'b1;
                if (17'(idx_q) == ({1'b0, len_q} - 17'd1)) begin
                    state_d = LD_DONE;
                end else begin
                    state_d = LD_BYTE;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase

        if (accept) tmr_clear = 1'b1;
    end

    // Registered-output decode, computed from the upcoming state
    always_comb begin
        len_ok_d    = (len_d != 16'd0) && ({1'b0, len_d} <= CAPACITY);
        byteReady_d = (state_d == LD_LEN_HI) || (state_d == LD_LEN_LO) ||
                      ((state_d == LD_BYTE) && len_ok_d);
        enter_write = (state_d == LD_WRITE) && (state_q != LD_WRITE);
    end

    // Control state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_IDLE;
            len_q   <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Output registers; write address/data are captured only on WRITE entry
    // so they hold their last values for the rest of the time.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteReady_q <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            cpuRst_q    <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            byteReady_q <= byteReady_d;
            wrEn_q      <= (state_d == LD_WRITE);
            cpuRst_q    <= (state_d != LD_DONE);
            done_q      <= (state_d == LD_DONE);
            error_q     <= (state_d == LD_ERROR);
            if (enter_write) begin
                wrAddr_q <= idx_q;
                wrData_q <= asm_d;
            end
        end
    end

    assign byteReady = byteReady_q;
    assign wrEn      = wrEn_q;
    assign wrAddr    = wrAddr_q;
    assign wrData    = wrData_q;
    assign cpuRst    = cpuRst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
